// File: rtl/mult_acc_pkg.sv
// Shared types and arithmetic helpers for the product accumulator.
package mult_acc_pkg;

    localparam int P_WIDTH_DEF   = 40;
    localparam int ACC_WIDTH_DEF = 48;

    // Working width of the saturating adder; accumulators must be narrower.
    localparam int SAT_MAX_W = 64;
    localparam logic signed [SAT_MAX_W:0] SAT_ONE = 1;

    // Beat markers travelling alongside the multiplier pipeline.
    typedef struct packed {
        logic vld;
        logic first;
        logic last;
    } marker_t;

    // Saturating adder result: clipped value plus a flag raised on clipping.
    typedef struct packed {
        logic                        sat;
        logic signed [SAT_MAX_W-1:0] val;
    } sat_res_t;

    // Width of an exact signed sum of n values of p_w bits each.
    function automatic int sum_width(input int p_w, input int n);
        return p_w + $clog2(n);
    endfunction

    // Signed add clipped to the range of a w-bit signed number (w < SAT_MAX_W).
    function automatic sat_res_t sat_add(input logic signed [SAT_MAX_W-1:0] a,
                                         input logic signed [SAT_MAX_W-1:0] b,
                                         input int w);
        logic signed [SAT_MAX_W:0] s;
        logic signed [SAT_MAX_W:0] hi;
        logic signed [SAT_MAX_W:0] lo;
        sat_res_t r;
        s  = {a[SAT_MAX_W-1], a} + {b[SAT_MAX_W-1], b};
        hi = (SAT_ONE <<< (w - 1)) - SAT_ONE;
        lo = -(SAT_ONE <<< (w - 1));
        r.sat = 1'b0;
        r.val = s[SAT_MAX_W-1:0];
        if (s > hi) begin
            r.sat = 1'b1;
            r.val = hi[SAT_MAX_W-1:0];
        end else if (s < lo) begin
            r.sat = 1'b1;
            r.val = lo[SAT_MAX_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/group_adder_tree.sv
// Combinational signed reduction of one group of product lanes.
module group_adder_tree
    import mult_acc_pkg::*;
#(
    parameter int  GROUP_SIZE = 48,
    parameter int  P_WIDTH    = P_WIDTH_DEF,
    localparam int SUM_W      = sum_width(P_WIDTH, GROUP_SIZE)
) (
    input  logic [GROUP_SIZE*P_WIDTH-1:0] lanes_i,
    output logic signed [SUM_W-1:0]       sum_o
);

    // Sign-extend every lane to the exact sum width and add; the result cannot overflow.
    always_comb begin
        sum_o = '0;
        for (int i = 0; i < GROUP_SIZE; i++) begin
            sum_o = sum_o + SUM_W'(signed'(lanes_i[i*P_WIDTH +: P_WIDTH]));
        end
    end

endmodule

// File: rtl/mult_product_accumulator.sv
// Reduces multiplier products per group, accumulates them over first/last windows
// and presents the window sums downstream with a valid/ready handshake.
module mult_product_accumulator
    import mult_acc_pkg::*;
#(
    parameter int  LANES        = 576,
    parameter int  GROUP_SIZE   = 48,
    parameter int  P_WIDTH      = P_WIDTH_DEF,
    parameter int  ACC_WIDTH    = ACC_WIDTH_DEF,
    parameter int  MULT_LATENCY = 2,
    localparam int NUM_GROUPS   = LANES / GROUP_SIZE
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    input  logic                             in_first,
    input  logic                             in_last,
    output logic                             in_ready,
    input  logic [LANES*P_WIDTH-1:0]         vector_P,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_GROUPS*ACC_WIDTH-1:0]  out_sums,
    output logic                             sat_flag,
    output logic                             ovf_err,
    input  logic                             clr_err
);

    localparam int SUM_W = sum_width(P_WIDTH, GROUP_SIZE);

    marker_t mk_in;
    marker_t mk_p0;

    // ---- issue -> product arrival: markers delayed to coincide with vector_P ----
    always_comb begin
        mk_in.vld   = in_valid;
        mk_in.first = in_valid & in_first;
        mk_in.last  = in_valid & in_last;
    end

    generate
        if (MULT_LATENCY == 0) begin : g_no_pipe
            assign mk_p0 = mk_in;
        end else begin : g_mpipe
            marker_t pipe_q [MULT_LATENCY];

            // Shift register matching the multiplier's fixed latency.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < MULT_LATENCY; i++) pipe_q[i] <= '0;
                end else begin
                    pipe_q[0] <= mk_in;
                    for (int i = 1; i < MULT_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end

            assign mk_p0 = pipe_q[MULT_LATENCY-1];
        end
    endgenerate

    // ---- stage R: per-group reduction registered ----
    logic signed [SUM_W-1:0] tree_sum [NUM_GROUPS];
    logic signed [SUM_W-1:0] rsum_p1_q [NUM_GROUPS];
    marker_t                 mk_p1_q;

    generate
        for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_tree
            group_adder_tree #(
                .GROUP_SIZE (GROUP_SIZE),
                .P_WIDTH    (P_WIDTH)
            ) u_tree (
                .lanes_i (vector_P[g*GROUP_SIZE*P_WIDTH +: GROUP_SIZE*P_WIDTH]),
                .sum_o   (tree_sum[g])
            );
        end
    endgenerate

    // Group sums are data only; they are qualified by the registered marker.
    always_ff @(posedge clk) begin
        if (mk_p0.vld) begin
            for (int g = 0; g < NUM_GROUPS; g++) rsum_p1_q[g] <= tree_sum[g];
        end
    end

    // Marker follows the group sums into stage A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mk_p1_q <= '0;
        else        mk_p1_q <= mk_p0;
    end

    // ---- stage A: saturating accumulation, window completion ----
    logic signed [ACC_WIDTH-1:0] acc_q  [NUM_GROUPS];
    logic signed [ACC_WIDTH-1:0] acc_nx [NUM_GROUPS];
    logic [NUM_GROUPS-1:0]       grp_sat;

    generate
        for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_acc
            logic signed [SAT_MAX_W-1:0] acc_base;
            sat_res_t                    res;
            logic                        unused_hi;

            // A first beat starts from zero so stale accumulator content never leaks in.
            assign acc_base  = mk_p1_q.first ? '0 : SAT_MAX_W'(acc_q[g]);
            assign res       = sat_add(acc_base, SAT_MAX_W'(rsum_p1_q[g]), ACC_WIDTH);
            assign acc_nx[g] = res.val[ACC_WIDTH-1:0];
            assign grp_sat[g] = mk_p1_q.vld & res.sat;
            assign unused_hi = ^res.val[SAT_MAX_W-1:ACC_WIDTH];
        end
    endgenerate

    logic                            load;
    logic                            drop;
    logic                            out_valid_q;
    logic                            out_valid_d;
    logic [NUM_GROUPS*ACC_WIDTH-1:0] out_sums_q;
    logic [NUM_GROUPS*ACC_WIDTH-1:0] out_sums_d;
    logic                            sat_q;
    logic                            sat_d;
    logic                            ovf_q;
    logic                            ovf_d;

    // Accumulators advance on valid beats only and clear once a window completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < NUM_GROUPS; g++) acc_q[g] <= '0;
        end else if (mk_p1_q.vld) begin
            for (int g = 0; g < NUM_GROUPS; g++) acc_q[g] <= mk_p1_q.last ? '0 : acc_nx[g];
        end
    end

    // Output register control: a completed window loads unless a held result blocks it.
    always_comb begin
        load        = mk_p1_q.vld & mk_p1_q.last & (~out_valid_q | out_ready);
        drop        = mk_p1_q.vld & mk_p1_q.last & out_valid_q & ~out_ready;
        out_valid_d = out_valid_q;
        out_sums_d  = out_sums_q;
        if (load) begin
            out_valid_d = 1'b1;
            for (int g = 0; g < NUM_GROUPS; g++) out_sums_d[g*ACC_WIDTH +: ACC_WIDTH] = acc_nx[g];
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        // A same-cycle set beats the clear.
        sat_d = (|grp_sat) | (sat_q & ~clr_err);
        ovf_d = drop | (ovf_q & ~clr_err);
    end

    // ---- output: held window result and sticky status ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_sums_q  <= '0;
            sat_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_sums_q  <= out_sums_d;
            sat_q       <= sat_d;
            ovf_q       <= ovf_d;
        end
    end

    assign in_ready  = ~out_valid_q | out_ready;
    assign out_valid = out_valid_q;
    assign out_sums  = out_sums_q;
    assign sat_flag  = sat_q;
    assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_mult_product_accumulator.sv
// Self-checking bench for mult_product_accumulator: table-driven windows plus
// hand-written corner sequences, with a scoreboard on the output handshake.
module tb_mult_product_accumulator;

    localparam int LANES = 8;
    localparam int GS    = 4;
    localparam int PW    = 40;
    localparam int AW    = 48;
    localparam int ML    = 2;
    localparam int NG    = LANES / GS;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid, in_first, in_last, in_ready;
    logic [LANES*PW-1:0] vector_P;
    logic                out_valid, out_ready;
    logic [NG*AW-1:0]    out_sums;
    logic                sat_flag, ovf_err, clr_err;

    int n_chk  = 0;
    int n_fail = 0;

    logic [95:0] sb_q [$];

    logic [LANES*PW-1:0] issue_p;
    logic [LANES*PW-1:0] p1_q, p2_q;

    typedef struct {
        longint v0;
        longint v1;
        bit     ramp;
        int     nb;
        longint e0;
        longint e1;
    } vec_t;

    vec_t tbl [7];

    mult_product_accumulator #(
        .LANES        (LANES),
        .GROUP_SIZE   (GS),
        .P_WIDTH      (PW),
        .ACC_WIDTH    (AW),
        .MULT_LATENCY (ML)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .vector_P  (vector_P),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sums  (out_sums),
        .sat_flag  (sat_flag),
        .ovf_err   (ovf_err),
        .clr_err   (clr_err)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: operands issued in cycle t appear on vector_P in cycle t+2.
    always @(posedge clk) begin
        p1_q <= issue_p;
        p2_q <= p1_q;
    end
    assign vector_P = p2_q;

    function automatic logic [95:0] pack(input longint s0, input longint s1);
        logic [63:0] a;
        logic [63:0] b;
        a = s0;
        b = s1;
        return {b[47:0], a[47:0]};
    endfunction

    function automatic logic [LANES*PW-1:0] lanes(input longint v0, input longint v1, input bit ramp);
        logic [LANES*PW-1:0] r;
        longint              v;
        logic [63:0]         u;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            v = ((i < GS) ? v0 : v1) + (ramp ? longint'(i % GS) : 64'sd0);
            u = v;
            r[i*PW +: PW] = u[PW-1:0];
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    // Scoreboard: compare each accepted result against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected: got %h, expected no output", out_sums);
            end else begin
                chk("sb_sums", out_sums, sb_q.pop_front());
            end
        end
    end

    task automatic beat(input bit f, input bit l, input longint v0, input longint v1, input bit ramp);
        in_valid = 1'b1;
        in_first = f;
        in_last  = l;
        issue_p  = lanes(v0, v1, ramp);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        issue_p  = '0;
    endtask

    task automatic window(input longint v0, input longint v1, input bit ramp, input int nb,
                          input longint e0, input longint e1);
        sb_q.push_back(pack(e0, e1));
        for (int b = 0; b < nb; b++) beat(b == 0, b == nb - 1, v0, v1, ramp);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_left", 96'(sb_q.size()), 96'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{3, 3, 1'b0, 1, 12, 12};
        tbl[1] = '{-5, 7, 1'b0, 3, -60, 84};
        tbl[2] = '{100, -1, 1'b0, 2, 800, -8};
        tbl[3] = '{-64'sd549755813888, 64'sd549755813887, 1'b0, 1, -64'sd2199023255552, 64'sd2199023255548};
        tbl[4] = '{0, 1, 1'b0, 5, 0, 20};
        tbl[5] = '{1000000, -3, 1'b0, 4, 16000000, -48};
        tbl[6] = '{10, -10, 1'b1, 2, 92, -68};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        issue_p   = '0;
        out_ready = 1'b1;
        clr_err   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_sums", out_sums, '0);
        chk1("rst_sat_flag", sat_flag, 1'b0);
        chk1("rst_ovf_err", ovf_err, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;

        // 1-beat window latency: valid appears exactly four cycles after issue
        sb_q.push_back(pack(12, 12));
        beat(1'b1, 1'b1, 3, 3, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk1($sformatf("lat_valid_t%0d", k), out_valid, k == 4);
        end
        @(posedge clk); #1;
        drain(10);

        // Table-driven windows
        for (int i = 0; i < 7; i++) begin
            window(tbl[i].v0, tbl[i].v1, tbl[i].ramp, tbl[i].nb, tbl[i].e0, tbl[i].e1);
            drain(20);
            chk1($sformatf("tbl%0d_idle_valid", i), out_valid, 1'b0);
        end
        chk1("pre_sat_flag", sat_flag, 1'b0);

        // Saturation in both directions, then clear
        window(64'sd549755813887, -64'sd549755813888, 1'b0, 200,
               64'sd140737488355327, -64'sd140737488355328);
        drain(20);
        chk1("sat_flag_set", sat_flag, 1'b1);
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
        chk1("sat_flag_clr", sat_flag, 1'b0);

        // Collision: held result stays, second window dropped, upstream stalled
        begin
            int  n;
            bit  rdy_seen;
            out_ready = 1'b0;
            beat(1'b1, 1'b1, 3, 3, 1'b0);
            n = 0;
            while (!out_valid && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk1("ovf_first_valid", out_valid, 1'b1);
            chk1("ovf_in_ready_low", in_ready, 1'b0);
            @(posedge clk); #1;
            rdy_seen = 1'b0;
            in_valid = 1'b1; in_first = 1'b1; in_last = 1'b0; issue_p = lanes(1, 1, 1'b0);
            @(negedge clk);
            if (in_ready) rdy_seen = 1'b1;
            @(posedge clk); #1;
            in_first = 1'b0; in_last = 1'b1;
            @(negedge clk);
            if (in_ready) rdy_seen = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0; in_last = 1'b0; issue_p = '0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if (in_ready) rdy_seen = 1'b1;
            end
            chk1("ovf_in_ready_held_low", rdy_seen, 1'b0);
            chk1("ovf_err_set", ovf_err, 1'b1);
            chk1("ovf_valid_held", out_valid, 1'b1);
            chk("ovf_sums_held", out_sums, pack(12, 12));
            @(posedge clk); #1;
            sb_q.push_back(pack(12, 12));
            out_ready = 1'b1;
            drain(10);
            chk1("ovf_err_sticky", ovf_err, 1'b1);
            chk1("ovf_no_sat", sat_flag, 1'b0);
            clr_err = 1'b1;
            @(posedge clk); #1;
            clr_err = 1'b0;
            chk1("ovf_err_clr", ovf_err, 1'b0);
        end

        // Back-to-back windows with continuous acceptance
        window(1, 2, 1'b0, 1, 4, 8);
        window(3, 4, 1'b0, 1, 12, 16);
        window(-1, -2, 1'b0, 1, -4, -8);
        window(5, -5, 1'b0, 1, 20, -20);
        window(2, 2, 1'b0, 2, 16, 16);
        window(1, -1, 1'b0, 2, 8, -8);
        drain(20);
        chk1("b2b_idle_valid", out_valid, 1'b0);

        // Reset mid-window: old beats must not reach the next result
        beat(1'b1, 1'b0, 5, 5, 1'b0);
        beat(1'b0, 1'b0, 5, 5, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk1("mrst_out_valid", out_valid, 1'b0);
        chk("mrst_out_sums", out_sums, '0);
        chk1("mrst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb_q.push_back(pack(8, 8));
        beat(1'b0, 1'b0, 1, 1, 1'b0);
        beat(1'b0, 1'b1, 1, 1, 1'b0);
        drain(20);
        chk1("mrst_sat_flag", sat_flag, 1'b0);
        chk1("mrst_ovf_err", ovf_err, 1'b0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
